// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types and constants for the SPI frame sequencer
package spi_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        WAIT,
        HOLD
    } spi_ctrl_state_t;

endpackage

// File: rtl/spi_send_ctrl_if.sv
// rtl/spi_send_ctrl_if.sv - byte handshake and chip-select between sequencer and SPI master core
interface spi_send_ctrl_if;

    logic [spi_ctrl_pkg::BYTE_W-1:0] spi_data_o;
    logic                            spi_valid_o;
    logic                            spi_ready_i;
    logic                            spi_done_i;
    logic                            cs_n_o;

    modport master (
        output spi_data_o,
        output spi_valid_o,
        output cs_n_o,
        input  spi_ready_i,
        input  spi_done_i
    );

    modport slave (
        input  spi_data_o,
        input  spi_valid_o,
        input  cs_n_o,
        output spi_ready_i,
        output spi_done_i
    );

endinterface

// File: rtl/spi_cs_timer.sv
// rtl/spi_cs_timer.sv - loadable down-counter timing chip-select setup and hold
module spi_cs_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         armed_q, armed_d;

    // Expires in the cycle the armed count reaches zero, so load value N-1 gives N cycles.
    assign expire_o = armed_q && (cnt_q == '0);

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (load_i) begin
            cnt_d   = load_val_i;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/spi_send_ctrl.sv
// rtl/spi_send_ctrl.sv - counter snapshot sent MSB byte first over SPI; SPI_SEND_CRC_EN appends XOR byte
module spi_send_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int CS_SETUP_CYC = 4,
    parameter int CS_HOLD_CYC  = 4
) (
    input  logic               clk_100,
    input  logic               a_rst,
    input  logic               count_pulse_i,
    input  logic               send_pulse_i,
    spi_send_ctrl_if.master    spi,
    output logic               busy_o,
    output logic               drop_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int NUM_BYTES = CNT_W / BYTE_W;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int TMR_W     = 8;

    spi_ctrl_state_t                     state_q, state_d;
    logic [CNT_W-1:0]                    count_q, count_d;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]    snap_q, snap_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic                                drop_q, drop_d;
    logic                                tmr_load;
    logic [TMR_W-1:0]                    tmr_val;
    logic                                tmr_expire;
    logic [BYTE_W-1:0]                   tx_byte;

    spi_cs_timer #(.W(TMR_W)) u_cs_timer (
        .clk        (clk_100),
        .rst_n      (a_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

`ifdef SPI_SEND_CRC_EN
    logic              crc_q, crc_d;
    logic [BYTE_W-1:0] crc_byte;

    always_comb begin
        crc_byte = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            crc_byte = crc_byte ^ snap_q[i];
        end
    end

    assign tx_byte = crc_q ? crc_byte : snap_q[idx_q];
`else
    assign tx_byte = snap_q[idx_q];
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_pulse_i ? count_q + CNT_W'(1) : count_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        drop_d   = send_pulse_i && (state_q != IDLE);
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef SPI_SEND_CRC_EN
        crc_d    = crc_q;
`endif
        case (state_q)
            IDLE: begin
                if (send_pulse_i) begin
                    // Snapshot takes the pre-increment value when a count pulse coincides.
                    snap_d   = count_q;
                    idx_d    = IDX_W'(NUM_BYTES - 1);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(CS_SETUP_CYC - 1);
                    state_d  = SETUP;
`ifdef SPI_SEND_CRC_EN
                    crc_d    = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (tmr_expire) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (spi.spi_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (spi.spi_done_i) begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = LOAD;
`ifdef SPI_SEND_CRC_EN
                    end else if (!crc_q) begin
                        crc_d   = 1'b1;
                        state_d = LOAD;
`endif
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(CS_HOLD_CYC - 1);
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tmr_expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge a_rst) begin
        if (!a_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            snap_q  <= '0;
            idx_q   <= '0;
            drop_q  <= 1'b0;
`ifdef SPI_SEND_CRC_EN
            crc_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
`ifdef SPI_SEND_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    // Chip-select releases in the last hold cycle so the done-to-release gap equals CS_HOLD_CYC.
    assign spi.cs_n_o      = (state_q == IDLE) || ((state_q == HOLD) && tmr_expire);
    assign spi.spi_valid_o = (state_q == LOAD);
    assign spi.spi_data_o  = (state_q == LOAD) ? tx_byte : '0;
    assign busy_o          = (state_q != IDLE);
    assign drop_o          = drop_q;
    assign count_o         = count_q;

endmodule

// File: tb/tb_spi_send_ctrl.sv
// tb/tb_spi_send_ctrl.sv - directed scoreboard bench for spi_send_ctrl (honours SPI_SEND_CRC_EN)
module tb_spi_send_ctrl;

    localparam int SETUP_C  = 4;
    localparam int HOLD_C   = 4;
    localparam int DONE_LAT = 3;
`ifdef SPI_SEND_CRC_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk_100 = 1'b0;
    logic        a_rst = 1'b0;
    logic        count_pulse_i = 1'b0;
    logic        send_pulse_i = 1'b0;
    logic        busy_o;
    logic        drop_o;
    logic [15:0] count_o;
    logic        ready_en = 1'b0;
    logic        done_r = 1'b0;
    logic        done_force = 1'b0;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          xfers = 0;
    int          done_cyc = 0;
    logic [7:0]  exp_q[$];

    always #5 clk_100 = ~clk_100;

    spi_send_ctrl_if spi ();
    assign spi.spi_ready_i = ready_en;
    assign spi.spi_done_i  = done_r | done_force;

    spi_send_ctrl #(
        .CNT_W        (16),
        .CS_SETUP_CYC (SETUP_C),
        .CS_HOLD_CYC  (HOLD_C)
    ) dut (
        .clk_100       (clk_100),
        .a_rst         (a_rst),
        .count_pulse_i (count_pulse_i),
        .send_pulse_i  (send_pulse_i),
        .spi           (spi),
        .busy_o        (busy_o),
        .drop_o        (drop_o),
        .count_o       (count_o)
    );

    always @(posedge clk_100) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI master model: accepts on valid&ready, pulses done DONE_LAT cycles later, scores bytes.
    initial begin
        int         done_cnt;
        logic       hold_prev;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        done_cnt  = 0;
        hold_prev = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk_100);
            if (!a_rst) begin
                done_r    = 1'b0;
                done_cnt  = 0;
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hs_valid_held", {31'b0, spi.spi_valid_o}, 32'd1);
                    check("hs_data_stable", {24'b0, spi.spi_data_o}, {24'b0, prev_data});
                end
                hold_prev = spi.spi_valid_o && !spi.spi_ready_i;
                prev_data = spi.spi_data_o;
                done_r    = 1'b0;
                if (done_cnt != 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        done_r   = 1'b1;
                        done_cyc = cyc;
                    end
                end
                if (spi.spi_valid_o && spi.spi_ready_i) begin
                    xfers++;
                    check("sb_byte_expected", {31'b0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        check("sb_byte", {24'b0, spi.spi_data_o}, {24'b0, exp_b});
                    end
                    done_cnt = DONE_LAT;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk_100);
        #1;
    endtask

    task automatic pulse_count(input int n);
        count_pulse_i = 1'b1;
        repeat (n) tick();
        count_pulse_i = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] v);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
`ifdef SPI_SEND_CRC_EN
        exp_q.push_back(v[15:8] ^ v[7:0]);
`endif
    endtask

    task automatic send_and_check_cs(input string tag);
        int n;
        send_pulse_i = 1'b1;
        tick();
        send_pulse_i = 1'b0;
        check({tag, "_cs_low_t1"}, {31'b0, spi.cs_n_o}, 32'd0);
        n = 0;
        while (spi.spi_valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_setup_lat"}, n, SETUP_C);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (spi.cs_n_o !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_end_in_time"}, {31'b0, n < 500}, 32'd1);
        check({tag, "_hold_gap"}, cyc - done_cyc, HOLD_C);
        repeat (2) tick();
    endtask

    initial begin
        int x0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            count_pulse_i = 1'($urandom);
            send_pulse_i  = 1'($urandom);
            ready_en      = 1'($urandom);
            done_force    = 1'($urandom);
            tick();
            check("rst_cs_n", {31'b0, spi.cs_n_o}, 32'd1);
            check("rst_valid", {31'b0, spi.spi_valid_o}, 32'd0);
            check("rst_data", {24'b0, spi.spi_data_o}, 32'd0);
            check("rst_busy", {31'b0, busy_o}, 32'd0);
            check("rst_drop", {31'b0, drop_o}, 32'd0);
            check("rst_count", {16'b0, count_o}, 32'd0);
        end
        count_pulse_i = 1'b0;
        send_pulse_i  = 1'b0;
        ready_en      = 1'b0;
        done_force    = 1'b0;
        tick();
        a_rst = 1'b1;
        tick();

        // Basic frame, MSB byte first, ready tied high
        pulse_count(16'h12A3);
        check("t2_count", {16'b0, count_o}, 32'h12A3);
        ready_en = 1'b1;
        x0 = xfers;
        push_frame(16'h12A3);
        send_and_check_cs("t2");
        check("t2_first_byte", {24'b0, spi.spi_data_o}, 32'h12);
        wait_idle("t2");
        check("t2_xfers", xfers - x0, NB);
        check("t2_sb_empty", exp_q.size(), 0);

        // Backpressure in LOAD
        ready_en = 1'b0;
        x0 = xfers;
        push_frame(16'h12A3);
        send_and_check_cs("t3");
        repeat (10) tick();
        check("t3_valid_held", {31'b0, spi.spi_valid_o}, 32'd1);
        check("t3_data_held", {24'b0, spi.spi_data_o}, 32'h12);
        check("t3_no_xfer_yet", xfers - x0, 0);
        ready_en = 1'b1;
        wait_idle("t3");
        check("t3_xfers", xfers - x0, NB);
        check("t3_sb_empty", exp_q.size(), 0);

        // Send and count pulses while waiting for done
        x0 = xfers;
        push_frame(16'h12A3);
        send_and_check_cs("t4");
        tick();
        send_pulse_i  = 1'b1;
        count_pulse_i = 1'b1;
        tick();
        send_pulse_i  = 1'b0;
        count_pulse_i = 1'b0;
        check("t4_drop_hi", {31'b0, drop_o}, 32'd1);
        tick();
        check("t4_drop_lo", {31'b0, drop_o}, 32'd0);
        wait_idle("t4");
        check("t4_count", {16'b0, count_o}, 32'h12A4);
        repeat (20) tick();
        check("t4_single_frame", {31'b0, busy_o}, 32'd0);
        check("t4_xfers", xfers - x0, NB);
        check("t4_sb_empty", exp_q.size(), 0);

        // Coincident count/send, stray done in SETUP, counter wrap
        a_rst = 1'b0;
        tick();
        a_rst = 1'b1;
        tick();
        pulse_count(16'h00FF);
        check("t5_count_pre", {16'b0, count_o}, 32'h00FF);
        x0 = xfers;
        push_frame(16'h00FF);
        send_pulse_i  = 1'b1;
        count_pulse_i = 1'b1;
        tick();
        send_pulse_i  = 1'b0;
        count_pulse_i = 1'b0;
        done_force    = 1'b1;
        tick();
        done_force    = 1'b0;
        wait_idle("t5");
        check("t5_count_post", {16'b0, count_o}, 32'h0100);
        check("t5_xfers", xfers - x0, NB);
        check("t5_sb_empty", exp_q.size(), 0);
        pulse_count(16'hFEFF);
        check("t5_count_max", {16'b0, count_o}, 32'hFFFF);
        pulse_count(1);
        check("t5_count_wrap", {16'b0, count_o}, 32'h0000);

        // Asynchronous reset mid-frame, then a clean frame
        pulse_count(16'h0034);
        x0 = xfers;
        exp_q.push_back(8'h00);
        send_and_check_cs("t6a");
        tick();
        a_rst = 1'b0;
        #1;
        check("t6_rst_cs_n", {31'b0, spi.cs_n_o}, 32'd1);
        check("t6_rst_valid", {31'b0, spi.spi_valid_o}, 32'd0);
        check("t6_rst_busy", {31'b0, busy_o}, 32'd0);
        check("t6_rst_count", {16'b0, count_o}, 32'd0);
        check("t6_abort_xfers", xfers - x0, 1);
        check("t6_abort_sb_empty", exp_q.size(), 0);
        tick();
        a_rst = 1'b1;
        tick();
        x0 = xfers;
        push_frame(16'h0000);
        send_and_check_cs("t6b");
        wait_idle("t6b");
        check("t6_xfers", xfers - x0, NB);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
